// File: rtl/avs_scratchpad_slave_if.sv
// Avalon-MM bus bundle between the accelerator master and the scratchpad slave.
// AVS_SCRATCHPAD_BYTEENABLE_EN adds the byteenable lane mask to the bundle.
interface avs_scratchpad_slave_if #(
  parameter int unsigned AVS_AVALONSLAVE_DATA_WIDTH    = 32,
  parameter int unsigned AVS_AVALONSLAVE_ADDRESS_WIDTH = 32
);
  logic [AVS_AVALONSLAVE_ADDRESS_WIDTH-1:0] AVS_AVALONSLAVE_ADDRESS;
  logic                                     AVS_AVALONSLAVE_READ;
  logic                                     AVS_AVALONSLAVE_WRITE;
  logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]    AVS_AVALONSLAVE_WRITEDATA;
  logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]    AVS_AVALONSLAVE_READDATA;
  logic                                     AVS_AVALONSLAVE_WAITREQUEST;
`ifdef AVS_SCRATCHPAD_BYTEENABLE_EN
  logic [AVS_AVALONSLAVE_DATA_WIDTH/8-1:0]  AVS_AVALONSLAVE_BYTEENABLE;
`endif

  modport master (
    output AVS_AVALONSLAVE_ADDRESS, AVS_AVALONSLAVE_READ, AVS_AVALONSLAVE_WRITE,
           AVS_AVALONSLAVE_WRITEDATA,
`ifdef AVS_SCRATCHPAD_BYTEENABLE_EN
           AVS_AVALONSLAVE_BYTEENABLE,
`endif
    input  AVS_AVALONSLAVE_READDATA, AVS_AVALONSLAVE_WAITREQUEST
  );

  modport slave (
    input  AVS_AVALONSLAVE_ADDRESS, AVS_AVALONSLAVE_READ, AVS_AVALONSLAVE_WRITE,
           AVS_AVALONSLAVE_WRITEDATA,
`ifdef AVS_SCRATCHPAD_BYTEENABLE_EN
           AVS_AVALONSLAVE_BYTEENABLE,
`endif
    output AVS_AVALONSLAVE_READDATA, AVS_AVALONSLAVE_WAITREQUEST
  );
endinterface

// File: rtl/avs_scratchpad_slave.sv
// Avalon-MM scratchpad slave: word-addressed RAM with WAIT_STATES cycles of waitrequest.
// AVS_SCRATCHPAD_BYTEENABLE_EN enables per-byte write masking.
module avs_scratchpad_slave #(
  parameter int unsigned AVS_AVALONSLAVE_DATA_WIDTH    = 32,
  parameter int unsigned AVS_AVALONSLAVE_ADDRESS_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2                    = 8,
  parameter int unsigned WAIT_STATES                   = 2
) (
  input  logic                  CSI_CLOCK_CLK,
  input  logic                  CSI_CLOCK_RESET,
  avs_scratchpad_slave_if.slave avs,
  output logic                  ACCESS_PULSE,
  output logic                  RANGE_ERR
);
  localparam int unsigned DW = AVS_AVALONSLAVE_DATA_WIDTH;
  localparam int unsigned AW = AVS_AVALONSLAVE_ADDRESS_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [AW-1:0]           addr_q;
  logic                    op_read_q;
  logic [DW-1:0]           wdata_q;
  logic                    in_range_q;
`ifdef AVS_SCRATCHPAD_BYTEENABLE_EN
  logic [DW/8-1:0]         be_q;
`endif

  logic [DW-1:0]           mem [2**DEPTH_LOG2];

  logic [AW-1:0]           cur_addr;
  logic                    cur_in_range;
  logic                    cur_read;
  logic [DW-1:0]           cur_word;

  // With zero wait states ACK is entered straight from IDLE, so the read word and
  // range check must come from the live bus rather than the latched request.
  always_comb begin
    cur_addr     = (state == ST_IDLE) ? avs.AVS_AVALONSLAVE_ADDRESS : addr_q;
    cur_read     = (state == ST_IDLE) ? avs.AVS_AVALONSLAVE_READ : op_read_q;
    cur_in_range = (cur_addr >> DEPTH_LOG2) == '0;
    cur_word     = cur_in_range ? mem[cur_addr[DEPTH_LOG2-1:0]] : '0;
  end

  always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
    if (CSI_CLOCK_RESET) begin
      state                        <= ST_IDLE;
      cnt                          <= '0;
      addr_q                       <= '0;
      op_read_q                    <= 1'b0;
      wdata_q                      <= '0;
      in_range_q                   <= 1'b0;
`ifdef AVS_SCRATCHPAD_BYTEENABLE_EN
      be_q                         <= '0;
`endif
      avs.AVS_AVALONSLAVE_WAITREQUEST <= 1'b1;
      avs.AVS_AVALONSLAVE_READDATA    <= '0;
      ACCESS_PULSE                 <= 1'b0;
      RANGE_ERR                    <= 1'b0;
    end else begin
      ACCESS_PULSE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (avs.AVS_AVALONSLAVE_READ || avs.AVS_AVALONSLAVE_WRITE) begin
            addr_q     <= avs.AVS_AVALONSLAVE_ADDRESS;
            op_read_q  <= avs.AVS_AVALONSLAVE_READ;
            wdata_q    <= avs.AVS_AVALONSLAVE_WRITEDATA;
            in_range_q <= cur_in_range;
`ifdef AVS_SCRATCHPAD_BYTEENABLE_EN
            be_q       <= avs.AVS_AVALONSLAVE_BYTEENABLE;
`endif
            if (WAIT_STATES != 0) begin
              cnt   <= 4'(WAIT_STATES - 1);
              state <= ST_WAIT;
            end else begin
              state                        <= ST_ACK;
              avs.AVS_AVALONSLAVE_WAITREQUEST <= 1'b0;
              ACCESS_PULSE                 <= 1'b1;
              if (!cur_in_range) RANGE_ERR <= 1'b1;
              if (cur_read) avs.AVS_AVALONSLAVE_READDATA <= cur_word;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state                        <= ST_ACK;
            avs.AVS_AVALONSLAVE_WAITREQUEST <= 1'b0;
            ACCESS_PULSE                 <= 1'b1;
            if (!cur_in_range) RANGE_ERR <= 1'b1;
            if (cur_read) avs.AVS_AVALONSLAVE_READDATA <= cur_word;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state                        <= ST_IDLE;
          avs.AVS_AVALONSLAVE_WAITREQUEST <= 1'b1;
        end
      endcase
    end
  end

  // RAM is deliberately outside the reset domain; a reset drops state out of ACK
  // asynchronously, so an interrupted write never reaches this commit.
  always_ff @(posedge CSI_CLOCK_CLK) begin
    if (state == ST_ACK && !op_read_q && in_range_q) begin
`ifdef AVS_SCRATCHPAD_BYTEENABLE_EN
      for (int unsigned i = 0; i < DW/8; i++) begin
        if (be_q[i]) mem[addr_q[DEPTH_LOG2-1:0]][i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
`else
      mem[addr_q[DEPTH_LOG2-1:0]] <= wdata_q;
`endif
    end
  end
endmodule

// File: tb/tb_avs_scratchpad_slave.sv
// Scoreboard bench for avs_scratchpad_slave: directed transfers push expected ACKs,
// a negedge monitor pops and checks latency, ACCESS_PULSE and READDATA.
module tb_avs_scratchpad_slave;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned WS = 2;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    int          ack_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic access_pulse;
  logic range_err;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  avs_scratchpad_slave_if #(
    .AVS_AVALONSLAVE_DATA_WIDTH   (DW),
    .AVS_AVALONSLAVE_ADDRESS_WIDTH(AW)
  ) bus ();

  avs_scratchpad_slave #(
    .AVS_AVALONSLAVE_DATA_WIDTH   (DW),
    .AVS_AVALONSLAVE_ADDRESS_WIDTH(AW),
    .DEPTH_LOG2                   (8),
    .WAIT_STATES                  (WS)
  ) dut (
    .CSI_CLOCK_CLK  (clk),
    .CSI_CLOCK_RESET(rst),
    .avs            (bus.slave),
    .ACCESS_PULSE   (access_pulse),
    .RANGE_ERR      (range_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (access_pulse !== !bus.AVS_AVALONSLAVE_WAITREQUEST) begin
        errors++;
        $display("FAIL pulse_vs_waitrequest cyc=%0d pulse=%b waitrequest=%b", cyc, access_pulse,
                 bus.AVS_AVALONSLAVE_WAITREQUEST);
      end
      if (bus.AVS_AVALONSLAVE_WAITREQUEST === 1'b0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack cyc=%0d got ack, expected none", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (cyc != e.ack_cyc) begin
            errors++;
            $display("FAIL ack_latency got cyc=%0d expected cyc=%0d", cyc, e.ack_cyc);
          end
          if (e.is_read) begin
            checks++;
            if (bus.AVS_AVALONSLAVE_READDATA !== e.data) begin
              errors++;
              $display("FAIL readdata got %h expected %h", bus.AVS_AVALONSLAVE_READDATA, e.data);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.AVS_AVALONSLAVE_READ      = 1'b0;
    bus.AVS_AVALONSLAVE_WRITE     = 1'b0;
    bus.AVS_AVALONSLAVE_ADDRESS   = 32'h0BAD_0003;
    bus.AVS_AVALONSLAVE_WRITEDATA = 32'hFFFF_FFFF;
`ifdef AVS_SCRATCHPAD_BYTEENABLE_EN
    bus.AVS_AVALONSLAVE_BYTEENABLE = 4'hF;
`endif
  endtask

  // Request held for one edge only; junk on the bus afterwards exercises latching.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] exp);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.AVS_AVALONSLAVE_READ      = rd;
    bus.AVS_AVALONSLAVE_WRITE     = wr;
    bus.AVS_AVALONSLAVE_ADDRESS   = addr;
    bus.AVS_AVALONSLAVE_WRITEDATA = wdata;
`ifdef AVS_SCRATCHPAD_BYTEENABLE_EN
    bus.AVS_AVALONSLAVE_BYTEENABLE = be;
`else
    if (be != 4'hF) $display("note: byteenable ignored in this build");
`endif
    e.is_read = rd;
    e.data    = exp;
    e.ack_cyc = cyc + 1 + int'(WS);
    sb.push_back(e);
    @(negedge clk);
    drive_idle();
    n = 0;
    while (bus.AVS_AVALONSLAVE_WAITREQUEST !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout addr=%h waitrequest stayed high, expected low", addr);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    drive_idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_waitrequest", 32'(bus.AVS_AVALONSLAVE_WAITREQUEST), 32'h1);
    check("reset_readdata", bus.AVS_AVALONSLAVE_READDATA, 32'h0);
    check("reset_range_err", 32'(range_err), 32'h0);
    check("reset_pulse", 32'(access_pulse), 32'h0);

    xfer(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, 32'h0);
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hCAFE_F00D);

    for (int i = 0; i < 4; i++) xfer(1'b0, 1'b1, 32'(i), 32'(i + 1), 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) xfer(1'b1, 1'b0, 32'(i), 32'h0, 4'hF, 32'(i + 1));

    check("range_err_before", 32'(range_err), 32'h0);
    xfer(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 32'h0);
    check("range_err_after_read", 32'(range_err), 32'h1);
    xfer(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0);
    check("range_err_sticky", 32'(range_err), 32'h1);
    xfer(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 32'h1);

    xfer(1'b0, 1'b1, 32'h5, 32'h11, 4'hF, 32'h0);
    xfer(1'b1, 1'b1, 32'h5, 32'h22, 4'hF, 32'h11);
    xfer(1'b1, 1'b0, 32'h5, 32'h0, 4'hF, 32'h11);

    xfer(1'b0, 1'b1, 32'h7, 32'h99, 4'hF, 32'h0);
    @(negedge clk);
    bus.AVS_AVALONSLAVE_WRITE     = 1'b1;
    bus.AVS_AVALONSLAVE_ADDRESS   = 32'h7;
    bus.AVS_AVALONSLAVE_WRITEDATA = 32'h55;
    @(negedge clk);
    drive_idle();
    #2 rst = 1'b1;
    #1;
    check("midreset_waitrequest", 32'(bus.AVS_AVALONSLAVE_WAITREQUEST), 32'h1);
    check("midreset_readdata", bus.AVS_AVALONSLAVE_READDATA, 32'h0);
    check("midreset_range_err", 32'(range_err), 32'h0);
    check("midreset_pulse", 32'(access_pulse), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    xfer(1'b1, 1'b0, 32'h7, 32'h0, 4'hF, 32'h99);

`ifdef AVS_SCRATCHPAD_BYTEENABLE_EN
    xfer(1'b0, 1'b1, 32'h20, 32'h0, 4'hF, 32'h0);
    xfer(1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0);
    xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h00BB_00DD);
    xfer(1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'h0, 32'h0);
    xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 32'h00BB_00DD);
`endif

    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete, expected completion");
    $fatal(1);
  end
endmodule
